// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, done pulse with held results.
// Define DIV_SIGNED_EN for two's-complement operands and results; the default build is unsigned.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH-1:0] p_diff, p_step, q_step;
  logic             p_ge_d;
  logic [WIDTH-1:0] dividend_mag, divisor_mag, q_final, r_final;

  // The remainder after each step is always below the divisor, so only the
  // freshly shifted value needs the extra (WIDTH+1)th bit.
  always_comb begin
    p_shift = {p_q, q_q[WIDTH-1]};
    p_diff  = p_shift[WIDTH-1:0] - d_q;
    p_ge_d  = (p_shift >= {1'b0, d_q});
    p_step  = p_ge_d ? p_diff : p_shift[WIDTH-1:0];
    q_step  = {q_q[WIDTH-2:0], p_ge_d};
  end

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;

  always_comb begin
    dividend_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
    q_final      = neg_q_q ? (~q_step + WIDTH'(1)) : q_step;
    r_final      = neg_r_q ? (~p_step + WIDTH'(1)) : p_step;
  end

  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (state_q == S_IDLE && start) begin
      neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_d = dividend[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
    q_final      = q_step;
    r_final      = p_step;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    q_d         = q_q;
    d_d         = d_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d         = divisor_mag;
          q_d         = dividend_mag;
          p_d         = '0;
          cnt_d       = CW'(WIDTH);
          quotient_d  = '0;
          remainder_d = '0;
          dbz_d       = 1'b0;
          if (divisor == '0) begin
            // Zero divisor skips the iteration and reports immediately.
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        p_d   = p_step;
        q_d   = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_DONE;
          quotient_d  = q_final;
          remainder_d = r_final;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      q_q         <= q_d;
      d_q         <= d_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=8); expectations come from a bench-side model.
module tb_seq_restoring_divider;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend, divisor;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // lat is the cycle index of done, counting the cycle right after the accepting edge as 1.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
`ifdef DIV_SIGNED_EN
    int sa, sb, qi, ri;
`endif
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = $signed(a); sb = $signed(b);
      qi = sa / sb;    ri = sa % sb;
      e.q = qi[7:0];   e.r = ri[7:0];
`else
      e.q = a / b;     e.r = a % b;
`endif
      e.dbz = 1'b0; e.lat = WIDTH + 1;
    end
    return e;
  endfunction

  // Drives one request and collects observations; callers compare.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] oq, output logic [7:0] orr, output logic odbz,
                        output int lat, output logic busy_ok, output logic after_ok);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    oq = quotient; orr = remainder; odbz = div_by_zero;
    @(posedge clk); #1;
    after_ok = (busy === 1'b0) && (done === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    // rst and start together: the request must be dropped
    @(negedge clk);
    dividend = 8'd9; divisor = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_dropped busy got=%b exp=0", busy); end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle busy got=%b exp=0", busy); end
    $display("reset: busy=%b done=%b q=%0d r=%0d dbz=%b", busy, done, quotient, remainder, div_by_zero);
  endtask

  task automatic test_ops(input string name, input int n_ops,
                          input logic [7:0] as_[8], input logic [7:0] bs[8]);
    logic [7:0] q, r; logic z, bok, aok; int lat; exp_t e;
    for (int i = 0; i < n_ops; i++) begin
      run_op(as_[i], bs[i], q, r, z, lat, bok, aok);
      e = sb_q.pop_front();
      $display("%s: %0d/%0d -> q=%0d r=%0d dbz=%b lat=%0d", name, as_[i], bs[i], q, r, z, lat);
      checks++; if (q !== e.q) begin errors++; $display("FAIL %s_q[%0d] got=%0d exp=%0d", name, i, q, e.q); end
      checks++; if (r !== e.r) begin errors++; $display("FAIL %s_r[%0d] got=%0d exp=%0d", name, i, r, e.r); end
      checks++; if (z !== e.dbz) begin errors++; $display("FAIL %s_dbz[%0d] got=%b exp=%b", name, i, z, e.dbz); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL %s_latency[%0d] got=%0d exp=%0d", name, i, lat, e.lat); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL %s_busy_during[%0d] got=%b exp=1", name, i, bok); end
      checks++; if (aok !== 1'b1) begin errors++; $display("FAIL %s_idle_after[%0d] got=%b exp=1", name, i, aok); end
    end
  endtask

  task automatic test_nominal();
    logic [7:0] as_[8], bs[8];
    as_ = '{8'd100, 8'd3, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
    bs  = '{8'd7,   8'd200, 8'd1, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
    test_ops("nominal", 4, as_, bs);
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r; logic z, bok, aok; int lat; exp_t e;
    run_op(8'd5, 8'd0, q, r, z, lat, bok, aok);
    e = sb_q.pop_front();
    $display("div_zero: 5/0 -> q=%0d r=%0d dbz=%b lat=%0d", q, r, z, lat);
    checks++; if (q !== e.q) begin errors++; $display("FAIL dz_q got=%0d exp=%0d", q, e.q); end
    checks++; if (r !== e.r) begin errors++; $display("FAIL dz_r got=%0d exp=%0d", r, e.r); end
    checks++; if (z !== e.dbz) begin errors++; $display("FAIL dz_flag got=%b exp=%b", z, e.dbz); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL dz_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (aok !== 1'b1) begin errors++; $display("FAIL dz_idle_after got=%b exp=1", aok); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
      errors++;
      $display("FAIL dz_held got=q%0d r%0d z%b exp=q%0d r%0d z%b", quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_busy_protection();
    exp_t e; int n; logic seen, extra;
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd9; start = 1'b1;
    sb_q.push_back(model(8'd200, 8'd9));
    @(posedge clk); #1;
    start = 1'b0; n = 1;
    repeat (3) begin @(posedge clk); #1; n++; end
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(posedge clk); #1; n++;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1; n++;
    end
    e = sb_q.pop_front();
    checks++; if (!seen || n !== e.lat) begin errors++; $display("FAIL busy_prot_latency got=%0d exp=%0d", seen ? n : -1, e.lat); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    extra = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (busy !== 1'b0 || done !== 1'b0) extra = 1'b1;
      @(posedge clk); #1;
    end
    $display("busy_prot: 200/9 -> q=%0d r=%0d lat=%0d extra=%b", quotient, remainder, n, extra);
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL busy_prot_second_run got=%b exp=0", extra); end
    checks++; if (quotient !== e.q) begin errors++; $display("FAIL busy_prot_q got=%0d exp=%0d", quotient, e.q); end
    checks++; if (remainder !== e.r) begin errors++; $display("FAIL busy_prot_r got=%0d exp=%0d", remainder, e.r); end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] q, r; logic z, bok, aok, stray; int lat; exp_t e;
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    sb_q.push_back(model(8'd100, 8'd7));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb_q.pop_front());
    $display("reset_mid: busy=%b done=%b q=%0d r=%0d dbz=%b", busy, done, quotient, remainder, div_by_zero);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl got=busy%b done%b exp=0", busy, done); end
    checks++; if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL mid_reset_results got=q%0d r%0d z%b exp=0", quotient, remainder, div_by_zero);
    end
    stray = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done !== 1'b0) stray = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL mid_reset_stray_done got=%b exp=0", stray); end
    run_op(8'd9, 8'd3, q, r, z, lat, bok, aok);
    e = sb_q.pop_front();
    $display("reset_mid: 9/3 -> q=%0d r=%0d lat=%0d", q, r, lat);
    checks++; if (q !== e.q || r !== e.r) begin errors++; $display("FAIL mid_reset_next got=%0d/%0d exp=%0d/%0d", q, r, e.q, e.r); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL mid_reset_next_latency got=%0d exp=%0d", lat, e.lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] as_[6], bs[6]; exp_t e; int edge_n, prev_done, idx;
    as_ = '{8'd100, 8'd37, 8'd250, 8'd0, 8'd0, 8'd0};
    bs  = '{8'd7,   8'd0,  8'd3,   8'd0, 8'd0, 8'd0};
    for (int i = 3; i < 6; i++) begin
      as_[i] = 8'($urandom_range(0, 255));
      bs[i]  = 8'($urandom_range(1, 255));
    end
    @(negedge clk);
    dividend = as_[0]; divisor = bs[0]; start = 1'b1;
    sb_q.push_back(model(as_[0], bs[0]));
    edge_n = 0; prev_done = -1; idx = 0;
    for (int k = 0; k < 200 && idx < 6; k++) begin
      @(posedge clk); #1; edge_n++;
      if (done === 1'b1) begin
        e = sb_q.pop_front();
        $display("b2b[%0d]: %0d/%0d -> q=%0d r=%0d dbz=%b edge=%0d", idx, as_[idx], bs[idx], quotient, remainder, div_by_zero, edge_n);
        checks++; if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
          errors++;
          $display("FAIL b2b_result[%0d] got=q%0d r%0d z%b exp=q%0d r%0d z%b", idx, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        checks++; if (edge_n !== prev_done + 1 + e.lat) begin
          errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", idx, edge_n, prev_done + 1 + e.lat);
        end
        prev_done = edge_n;
        idx++;
        if (idx < 6) begin
          dividend = as_[idx]; divisor = bs[idx];
          sb_q.push_back(model(as_[idx], bs[idx]));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++; if (idx !== 6) begin errors++; $display("FAIL b2b_timeout got=%0d exp=6", idx); end
    sb_q.delete();
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [7:0] as_[8], bs[8];
    as_ = '{8'hF9, 8'h80, 8'h07, 8'h80, 8'hF9, 8'd0, 8'd0, 8'd0};
    bs  = '{8'd2,  8'hFF, 8'hFE, 8'h00, 8'hF9, 8'd0, 8'd0, 8'd0};
    test_ops("signed", 5, as_, bs);
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_div_zero();
    test_busy_protection();
    test_reset_mid_op();
    test_back_to_back();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
